// File: rtl/tgen_pkg.sv
// tgen shared types and constants.
// Used by the RX deserialiser and its output FIFO.
package tgen_pkg;

    localparam int NIB_W        = 4;
    localparam int NIB_PER_WORD = 8;
    localparam int WORD_W       = 32;

    typedef enum logic [1:0] {
        IDLE,
        HUNT,
        SHIFT
    } tgen_rx_state_e;

endpackage

// File: rtl/tgen_rx_fifo.sv
// tgen RX output buffer: DEPTH x 32-bit synchronous FIFO.
// A push into a full FIFO is taken when a pop happens on the same edge.
module tgen_rx_fifo
    import tgen_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              push,
    input  logic [WORD_W-1:0] wdata,
    input  logic              pop,
    output logic              push_ok,
    output logic              full,
    output logic              empty,
    output logic [WORD_W-1:0] rdata
);

    localparam int AW = $clog2(DEPTH);

    logic [WORD_W-1:0] mem [DEPTH];
    logic [AW:0]       wptr;
    logic [AW:0]       rptr;
    logic              pop_ok;

    assign empty   = (wptr == rptr);
    assign full    = (wptr[AW] != rptr[AW]) &&
                     (wptr[AW-1:0] == rptr[AW-1:0]);
    assign pop_ok  = pop & ~empty & ~clr;
    assign push_ok = push & ~clr & (~full | pop_ok);
    assign rdata   = empty ? '0 : mem[rptr[AW-1:0]];

    // Pointer update; clr flushes and beats any push or pop.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            wptr <= '0;
            rptr <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop_ok)  rptr <= rptr + 1'b1;
        end
    end

    // Storage write; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push_ok) mem[wptr[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/tgen_rx_deser.sv
// tgen RX deserialiser: packs 8 pad nibbles (MSB first, WRD on the
// first) into 32-bit words and buffers them toward the uDMA RX FIFO.
module tgen_rx_deser
    import tgen_pkg::*;
#(
    parameter int FIFO_DEPTH = 2,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 periph_clk_i,
    input  logic                 rst_i,
    input  logic                 en_i,
    input  logic                 clr_i,
    input  logic                 sample_en_i,
    input  logic [NIB_W-1:0]     data_i,
    input  logic                 wrd_i,
    output logic [WORD_W-1:0]    data_o,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [CNT_WIDTH-1:0] word_cnt_o,
    output logic                 ovf_o,
    output logic                 frame_err_o,
    output logic                 busy_o,
    output logic                 event_o
);

    tgen_rx_state_e    state;
    tgen_rx_state_e    state_nxt;
    logic [2:0]        nib_cnt;
    logic [2:0]        nib_cnt_nxt;
    logic [WORD_W-1:0] sr;
    logic [WORD_W-1:0] sr_nxt;
    logic [WORD_W-1:0] word;
    logic [4:0]        sh;
    logic              push_req;
    logic              push_ok;
    logic              ferr_set;
    logic              full;
    logic              empty;
    logic              pop;

    // Nibble lands at position 7-count; lower positions are still zero.
    assign sh   = {3'd7 - nib_cnt, 2'b00};
    assign word = sr | (WORD_W'(data_i) << sh);
    assign pop  = valid_o & ready_i;

    // Next-state, shift register and push request.
    always_comb begin
        state_nxt   = state;
        nib_cnt_nxt = nib_cnt;
        sr_nxt      = sr;
        push_req    = 1'b0;
        ferr_set    = 1'b0;
        unique case (state)
            IDLE: begin
                if (en_i) state_nxt = HUNT;
            end
            HUNT: begin
                if (sample_en_i && wrd_i) begin
                    sr_nxt      = {data_i, 28'd0};
                    nib_cnt_nxt = 3'd1;
                    state_nxt   = SHIFT;
                end
            end
            SHIFT: begin
                if (sample_en_i) begin
                    if (wrd_i) begin
                        ferr_set    = 1'b1;
                        sr_nxt      = {data_i, 28'd0};
                        nib_cnt_nxt = 3'd1;
                    end else if (nib_cnt == 3'd7) begin
                        push_req    = 1'b1;
                        sr_nxt      = '0;
                        nib_cnt_nxt = 3'd0;
                        state_nxt   = HUNT;
                    end else begin
                        sr_nxt      = word;
                        nib_cnt_nxt = nib_cnt + 3'd1;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
        if (!en_i || clr_i) begin
            state_nxt   = (en_i && clr_i) ? HUNT : IDLE;
            nib_cnt_nxt = 3'd0;
            sr_nxt      = '0;
            push_req    = 1'b0;
            ferr_set    = 1'b0;
        end
    end

    // FSM, nibble count and partial word registers.
    always_ff @(posedge periph_clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            nib_cnt <= 3'd0;
            sr      <= '0;
        end else begin
            state   <= state_nxt;
            nib_cnt <= nib_cnt_nxt;
            sr      <= sr_nxt;
        end
    end

    // Word counter, sticky flags and push event.
    always_ff @(posedge periph_clk_i) begin
        if (rst_i || clr_i) begin
            word_cnt_o  <= '0;
            ovf_o       <= 1'b0;
            frame_err_o <= 1'b0;
            event_o     <= 1'b0;
        end else begin
            event_o <= push_ok;
            if (push_ok)             word_cnt_o  <= word_cnt_o + 1'b1;
            if (push_req && !push_ok) ovf_o      <= 1'b1;
            if (ferr_set)            frame_err_o <= 1'b1;
        end
    end

    assign busy_o  = (state == SHIFT);
    assign valid_o = ~empty;

    tgen_rx_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (periph_clk_i),
        .rst     (rst_i),
        .clr     (clr_i),
        .push    (push_req),
        .wdata   (word),
        .pop     (pop),
        .push_ok (push_ok),
        .full    (full),
        .empty   (empty),
        .rdata   (data_o)
    );

endmodule

// File: tb/tb_tgen_rx_deser.sv
// Self-checking bench for tgen_rx_deser.
// Directed scenarios plus a randomized run against a queue-based model.
module tb_tgen_rx_deser;

    localparam int DEPTH = 2;
    localparam int CW    = 16;

    logic          clk = 1'b0;
    logic          rst_i = 1'b1;
    logic          en_i = 1'b0;
    logic          clr_i = 1'b0;
    logic          sample_en_i = 1'b0;
    logic [3:0]    data_i = '0;
    logic          wrd_i = 1'b0;
    logic [31:0]   data_o;
    logic          valid_o;
    logic          ready_i = 1'b0;
    logic [CW-1:0] word_cnt_o;
    logic          ovf_o;
    logic          frame_err_o;
    logic          busy_o;
    logic          event_o;

    int errors = 0;
    int checks = 0;

    // Reference model state: buffered words, nibbles of the word being
    // collected (empty while hunting), enabled-last-cycle, flags.
    logic [31:0]   m_fifo[$];
    logic [3:0]    m_nibs[$];
    bit            m_active;
    logic [CW-1:0] m_cnt;
    bit            m_ovf;
    bit            m_ferr;
    bit            m_evt;

    always #5 clk = ~clk;

    tgen_rx_deser #(
        .FIFO_DEPTH (DEPTH),
        .CNT_WIDTH  (CW)
    ) dut (
        .periph_clk_i (clk),
        .rst_i        (rst_i),
        .en_i         (en_i),
        .clr_i        (clr_i),
        .sample_en_i  (sample_en_i),
        .data_i       (data_i),
        .wrd_i        (wrd_i),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .word_cnt_o   (word_cnt_o),
        .ovf_o        (ovf_o),
        .frame_err_o  (frame_err_o),
        .busy_o       (busy_o),
        .event_o      (event_o)
    );

    function automatic logic [31:0] fold();
        logic [31:0] w = '0;
        foreach (m_nibs[i]) w = {w[27:0], m_nibs[i]};
        return w;
    endfunction

    function automatic logic [31:0] m_head();
        return (m_fifo.size() > 0) ? m_fifo[0] : 32'd0;
    endfunction

    // One clock edge: advance the model from the inputs seen at the edge,
    // then leave #1 so outputs can be sampled away from the edge.
    task automatic step();
        bit          pop;
        bit          push;
        bit          acc;
        logic [31:0] w;
        @(posedge clk);
        push = 0;
        w    = '0;
        if (rst_i) begin
            m_fifo.delete(); m_nibs.delete();
            m_active = 0; m_cnt = '0;
            m_ovf = 0; m_ferr = 0; m_evt = 0;
        end else if (clr_i) begin
            m_fifo.delete(); m_nibs.delete();
            m_active = en_i; m_cnt = '0;
            m_ovf = 0; m_ferr = 0; m_evt = 0;
        end else begin
            pop = (m_fifo.size() > 0) && ready_i;
            if (!en_i) begin
                m_active = 0;
                m_nibs.delete();
            end else if (!m_active) begin
                m_active = 1;
            end else if (sample_en_i) begin
                if (wrd_i) begin
                    if (m_nibs.size() > 0) m_ferr = 1;
                    m_nibs.delete();
                    m_nibs.push_back(data_i);
                end else if (m_nibs.size() > 0) begin
                    m_nibs.push_back(data_i);
                    if (m_nibs.size() == 8) begin
                        w = fold();
                        m_nibs.delete();
                        push = 1;
                    end
                end
            end
            acc = push && ((m_fifo.size() < DEPTH) || pop);
            if (pop) void'(m_fifo.pop_front());
            if (acc) begin
                m_fifo.push_back(w);
                m_cnt = m_cnt + 1'b1;
            end
            if (push && !acc) m_ovf = 1;
            m_evt = acc;
        end
        #1;
    endtask

    task automatic send_nib(input logic [3:0] d, input bit w, input int gap);
        sample_en_i = 1'b1;
        data_i      = d;
        wrd_i       = w;
        step();
        sample_en_i = 1'b0;
        wrd_i       = 1'b0;
        repeat (gap) step();
    endtask

    task automatic send_word(input logic [31:0] word, input int gap);
        for (int i = 7; i >= 0; i--)
            send_nib(word[4*i +: 4], i == 7, (i > 0) ? gap : 0);
    endtask

    task automatic pulse_clr();
        clr_i = 1'b1;
        step();
        clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        en_i  = 1'b1;
        step();
        step();
        if ({valid_o, ovf_o, frame_err_o, busy_o, event_o} !== 5'b0) begin
            errors++;
            $display("FAIL reset_flags got %b exp 00000",
                     {valid_o, ovf_o, frame_err_o, busy_o, event_o});
        end
        checks++;
        if (data_o !== 32'd0 || word_cnt_o !== '0) begin
            errors++;
            $display("FAIL reset_data got %h/%0d exp 0/0", data_o, word_cnt_o);
        end
        checks++;
        rst_i = 1'b0;
        en_i  = 1'b0;
        step();
    endtask

    task automatic test_basic();
        en_i    = 1'b1;
        ready_i = 1'b1;
        step();
        for (int i = 1; i <= 8; i++) send_nib(4'(i), i == 1, 0);
        if (!valid_o || data_o !== 32'h12345678) begin
            errors++;
            $display("FAIL basic_word got v=%b %h exp v=1 12345678", valid_o, data_o);
        end
        checks++;
        if (event_o !== 1'b1 || word_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL basic_event got e=%b cnt=%0d exp e=1 cnt=1",
                     event_o, word_cnt_o);
        end
        checks++;
        step();
        if (valid_o !== 1'b0 || event_o !== 1'b0) begin
            errors++;
            $display("FAIL basic_pop got v=%b e=%b exp 0 0", valid_o, event_o);
        end
        checks++;
    endtask

    task automatic test_no_wrd();
        pulse_clr();
        for (int i = 0; i < 8; i++) send_nib(4'($urandom), 0, 0);
        if (busy_o !== 1'b0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL nowrd_ignored got busy=%b v=%b exp 0 0", busy_o, valid_o);
        end
        checks++;
        send_word(32'hABCDEF01, 1);
        if (data_o !== 32'hABCDEF01 || frame_err_o !== 1'b0 ||
            word_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL nowrd_word got %h ferr=%b cnt=%0d exp abcdef01 0 1",
                     data_o, frame_err_o, word_cnt_o);
        end
        checks++;
        step();
    endtask

    task automatic test_frame_err();
        pulse_clr();
        send_nib(4'h1, 1, 0);
        send_nib(4'h2, 0, 0);
        send_nib(4'h3, 0, 0);
        send_word(32'h98765432, 0);
        if (frame_err_o !== 1'b1 || data_o !== 32'h98765432 ||
            word_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL frame_err got ferr=%b %h cnt=%0d exp 1 98765432 1",
                     frame_err_o, data_o, word_cnt_o);
        end
        checks++;
        step();
        if (valid_o !== 1'b0 || frame_err_o !== 1'b1) begin
            errors++;
            $display("FAIL frame_single got v=%b ferr=%b exp 0 1", valid_o, frame_err_o);
        end
        checks++;
    endtask

    task automatic test_overflow();
        pulse_clr();
        ready_i = 1'b0;
        send_word(32'h11111111, 0);
        send_word(32'h22222222, 0);
        if (ovf_o !== 1'b0 || word_cnt_o !== 16'd2) begin
            errors++;
            $display("FAIL ovf_full got ovf=%b cnt=%0d exp 0 2", ovf_o, word_cnt_o);
        end
        checks++;
        send_word(32'h33333333, 0);
        if (ovf_o !== 1'b1 || word_cnt_o !== 16'd2 || event_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_drop got ovf=%b cnt=%0d e=%b exp 1 2 0",
                     ovf_o, word_cnt_o, event_o);
        end
        checks++;
        if (data_o !== 32'h11111111) begin
            errors++;
            $display("FAIL ovf_hold got %h exp 11111111", data_o);
        end
        checks++;
        ready_i = 1'b1;
        step();
        if (!valid_o || data_o !== 32'h22222222) begin
            errors++;
            $display("FAIL ovf_pop2 got v=%b %h exp 1 22222222", valid_o, data_o);
        end
        checks++;
        step();
        if (valid_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_empty got v=%b exp 0", valid_o);
        end
        checks++;
        pulse_clr();
        if (ovf_o !== 1'b0 || word_cnt_o !== '0 || valid_o !== 1'b0) begin
            errors++;
            $display("FAIL ovf_clr got ovf=%b cnt=%0d v=%b exp 0 0 0",
                     ovf_o, word_cnt_o, valid_o);
        end
        checks++;
    endtask

    task automatic test_full_pop();
        logic [31:0] w3;
        pulse_clr();
        ready_i = 1'b0;
        w3      = 32'h5A5AC3C3;
        send_word(32'hDEADBEEF, 0);
        send_word(32'h0BADF00D, 0);
        for (int i = 7; i >= 1; i--) send_nib(w3[4*i +: 4], i == 7, 0);
        ready_i = 1'b1;
        send_nib(w3[3:0], 0, 0);
        ready_i = 1'b0;
        if (ovf_o !== 1'b0 || word_cnt_o !== 16'd3 || event_o !== 1'b1) begin
            errors++;
            $display("FAIL fullpop_accept got ovf=%b cnt=%0d e=%b exp 0 3 1",
                     ovf_o, word_cnt_o, event_o);
        end
        checks++;
        if (data_o !== 32'h0BADF00D) begin
            errors++;
            $display("FAIL fullpop_head got %h exp 0badf00d", data_o);
        end
        checks++;
        ready_i = 1'b1;
        step();
        if (data_o !== w3 || !valid_o) begin
            errors++;
            $display("FAIL fullpop_third got v=%b %h exp 1 %h", valid_o, data_o, w3);
        end
        checks++;
        step();
    endtask

    task automatic test_abort();
        pulse_clr();
        ready_i = 1'b1;
        send_nib(4'hF, 1, 0);
        for (int i = 0; i < 3; i++) send_nib(4'h7, 0, 0);
        if (busy_o !== 1'b1) begin
            errors++;
            $display("FAIL abort_busy got %b exp 1", busy_o);
        end
        checks++;
        en_i = 1'b0;
        step();
        step();
        en_i = 1'b1;
        step();
        send_word(32'hCAFEF00D, 0);
        if (data_o !== 32'hCAFEF00D || word_cnt_o !== 16'd1) begin
            errors++;
            $display("FAIL abort_en got %h cnt=%0d exp cafef00d 1", data_o, word_cnt_o);
        end
        checks++;
        step();
        send_nib(4'h1, 1, 0);
        for (int i = 0; i < 3; i++) send_nib(4'h2, 0, 0);
        rst_i = 1'b1;
        step();
        if ({valid_o, ovf_o, frame_err_o, busy_o, event_o} !== 5'b0 ||
            data_o !== 32'd0 || word_cnt_o !== '0) begin
            errors++;
            $display("FAIL abort_rst got %b %h %0d exp all zero",
                     {valid_o, ovf_o, frame_err_o, busy_o, event_o},
                     data_o, word_cnt_o);
        end
        checks++;
        rst_i = 1'b0;
        step();
        send_word(32'hCAFEF00D, 1);
        if (data_o !== 32'hCAFEF00D || word_cnt_o !== 16'd1 ||
            frame_err_o !== 1'b0) begin
            errors++;
            $display("FAIL abort_rst_word got %h cnt=%0d ferr=%b exp cafef00d 1 0",
                     data_o, word_cnt_o, frame_err_o);
        end
        checks++;
        step();
    endtask

    task automatic test_random();
        int since = 8;
        int bad   = 0;
        pulse_clr();
        for (int c = 0; c < 3000; c++) begin
            en_i        = ($urandom_range(0, 199) != 0);
            clr_i       = ($urandom_range(0, 399) == 0);
            ready_i     = ($urandom_range(0, 3) != 0);
            sample_en_i = ($urandom_range(0, 2) != 0);
            data_i      = 4'($urandom);
            wrd_i       = 1'b0;
            if (sample_en_i) begin
                wrd_i = (since >= 8) || ($urandom_range(0, 59) == 0);
                since = wrd_i ? 1 : since + 1;
            end
            step();
            if (valid_o !== (m_fifo.size() > 0) || data_o !== m_head()) begin
                errors++; bad++;
                if (bad < 10)
                    $display("FAIL rand_out c=%0d got v=%b %h exp v=%b %h",
                             c, valid_o, data_o, m_fifo.size() > 0, m_head());
            end
            checks++;
            if (word_cnt_o !== m_cnt || event_o !== m_evt) begin
                errors++; bad++;
                if (bad < 10)
                    $display("FAIL rand_cnt c=%0d got %0d/%b exp %0d/%b",
                             c, word_cnt_o, event_o, m_cnt, m_evt);
            end
            checks++;
            if (ovf_o !== m_ovf || frame_err_o !== m_ferr ||
                busy_o !== (m_nibs.size() > 0)) begin
                errors++; bad++;
                if (bad < 10)
                    $display("FAIL rand_flags c=%0d got %b%b%b exp %b%b%b",
                             c, ovf_o, frame_err_o, busy_o,
                             m_ovf, m_ferr, m_nibs.size() > 0);
            end
            checks++;
        end
        clr_i       = 1'b0;
        sample_en_i = 1'b0;
        wrd_i       = 1'b0;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_wrd();
        test_frame_err();
        test_overflow();
        test_full_pop();
        test_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
